// File: rtl/aes_sub_bytes_engine.sv
// Multi-cycle AES SubBytes engine: accepts a block over valid/ready, substitutes
// LANES bytes per cycle through the forward or inverse S-box, returns the block.
module aes_sub_bytes_engine #(
    parameter int DATA_BYTES = 16,
    parameter int LANES      = 4,
    parameter int ENABLE_INV = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*DATA_BYTES-1:0] in_data,
    input  logic                    in_inv,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*DATA_BYTES-1:0] out_data
);

    localparam int PASSES = DATA_BYTES / LANES;
    localparam int CW     = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int LW     = 8 * LANES;

    if (DATA_BYTES < 1 || LANES < 1 || (DATA_BYTES % LANES) != 0) begin : g_bad_params
        $error("aes_sub_bytes_engine: LANES must divide DATA_BYTES and both must be >= 1");
    end

    // Table entry x sits at index x; row r holds entries 16r..16r+15.
    localparam logic [0:255][7:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        return SBOX_FWD[x];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return SBOX_INV[x];
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [CW-1:0]           pass_r;
    logic [8*DATA_BYTES-1:0] src_r;
    logic [8*DATA_BYTES-1:0] res_r;
    logic                    inv_r;
    logic                    use_inv_s;
    logic                    accept_s;
    logic                    last_pass_s;
    logic [LW-1:0]           lane_in_s;
    logic [LW-1:0]           lane_out_s;

    assign accept_s    = (state_r == IDLE) && in_valid;
    assign last_pass_s = (pass_r == CW'(PASSES - 1));
    assign use_inv_s   = (ENABLE_INV != 0) && inv_r;

    // Lane datapath: one S-box level between source slice and result slice.
    always_comb begin
        lane_in_s  = src_r[int'(pass_r) * LW +: LW];
        lane_out_s = '0;
        for (int i = 0; i < LANES; i++) begin
            if (use_inv_s) begin
                lane_out_s[8*i +: 8] = sbox_inv(lane_in_s[8*i +: 8]);
            end else begin
                lane_out_s[8*i +: 8] = sbox_fwd(lane_in_s[8*i +: 8]);
            end
        end
    end

    // Next-state decode for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (last_pass_s) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, pass counter, latched block/mode and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            pass_r  <= '0;
            src_r   <= '0;
            res_r   <= '0;
            inv_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                src_r  <= in_data;
                inv_r  <= (ENABLE_INV != 0) ? in_inv : 1'b0;
                pass_r <= '0;
            end else if (state_r == BUSY) begin
                res_r[int'(pass_r) * LW +: LW] <= lane_out_s;
                pass_r <= pass_r + 1'b1;
            end else begin
                pass_r <= pass_r;
            end
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign out_data  = res_r;

endmodule

// File: tb/tb_aes_sub_bytes_engine.sv
// Directed bench for aes_sub_bytes_engine: default 16/4 instance plus a 4/4
// forward-only instance, checked against hand-computed S-box vectors.
module tb_aes_sub_bytes_engine;

    logic         clk;
    logic         rst_n;

    logic         a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready;
    logic [127:0] a_in_data, a_out_data;
    logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready;
    logic [31:0]  b_in_data, b_out_data;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] FWD_IN  = 128'h0000_0000_0000_0000_0000_0000_ff53_0100;
    localparam logic [127:0] FWD_EXP = 128'h6363_6363_6363_6363_6363_6363_16ed_7c63;
    localparam logic [127:0] ALL_53  = 128'h5353_5353_5353_5353_5353_5353_5353_5353;
    localparam logic [127:0] ALL_ED  = 128'heded_eded_eded_eded_eded_eded_eded_eded;

    aes_sub_bytes_engine u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_inv    (a_in_inv),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data)
    );

    aes_sub_bytes_engine #(.DATA_BYTES(4), .LANES(4), .ENABLE_INV(0)) u_dut_fwd (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_inv    (b_in_inv),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one block, measure latency (acceptance edge counts as 1), capture and drain.
    task automatic run_blk(input bit sel_b, input logic [127:0] d, input logic inv,
                           input int exp_lat, input string tag, output logic [127:0] got);
        int n;
        chk({tag, "_in_ready"}, 128'(sel_b ? b_in_ready : a_in_ready), 128'd1);
        if (sel_b) begin
            b_in_data = d[31:0]; b_in_inv = inv; b_in_valid = 1'b1;
        end else begin
            a_in_data = d; a_in_inv = inv; a_in_valid = 1'b1;
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_in_data  = '1;   b_in_data  = '1;
        a_in_inv   = ~inv; b_in_inv   = ~inv;
        n = 1;
        while (((sel_b ? b_out_valid : a_out_valid) == 1'b0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 128'(n), 128'(exp_lat));
        got = sel_b ? {96'd0, b_out_data} : a_out_data;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0; b_out_ready = 1'b0;
        chk({tag, "_drained"}, 128'(sel_b ? b_out_valid : a_out_valid), 128'd0);
    endtask

    logic [127:0] got;
    logic [127:0] blk;
    logic [127:0] fw [16];
    logic         stray;
    int           n;

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_inv = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_inv = 1'b0; b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  128'(a_in_ready),  128'd1);
        chk("rst_out_valid", 128'(a_out_valid), 128'd0);
        chk("rst_out_data",  a_out_data,        128'd0);
        chk("rst_b_out_data", 128'(b_out_data), 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Forward and inverse on the reference block
        run_blk(1'b0, FWD_IN, 1'b0, 5, "fwd", got);
        chk("fwd_data", got, FWD_EXP);
        run_blk(1'b0, FWD_EXP, 1'b1, 5, "inv", got);
        chk("inv_data", got, FWD_IN);

        // All 256 byte values forward, then inverse must restore them
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'(16*b + i);
            run_blk(1'b0, blk, 1'b0, 5, "sweep_fwd", fw[b]);
        end
        chk("sweep_row0",  fw[0],  128'h76abd7fe2b670130c56f6bf27b777c63);
        chk("sweep_row15", fw[15], 128'h16bb54b00f2d99416842e6bf0d89a18c);
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'(16*b + i);
            run_blk(1'b0, fw[b], 1'b1, 5, "sweep_inv", got);
            chk("sweep_roundtrip", got, blk);
        end

        // Backpressure with in_valid held and inputs toggling
        a_in_data = FWD_IN; a_in_inv = 1'b0; a_in_valid = 1'b1;
        @(posedge clk); #1;
        n = 1;
        while (!a_out_valid && n < 50) begin
            a_in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            a_in_inv  = ~a_in_inv;
            @(posedge clk); #1;
            n++;
        end
        chk("bp_latency", 128'(n), 128'd5);
        for (int c = 0; c < 20; c++) begin
            chk("bp_out_valid", 128'(a_out_valid), 128'd1);
            chk("bp_in_ready",  128'(a_in_ready),  128'd0);
            chk("bp_out_data",  a_out_data,        FWD_EXP);
            a_in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            a_in_inv  = ~a_in_inv;
            @(posedge clk); #1;
        end
        a_in_data = ALL_53; a_in_inv = 1'b0; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        chk("bp_after_hs_in_ready",  128'(a_in_ready),  128'd1);
        chk("bp_after_hs_out_valid", 128'(a_out_valid), 128'd0);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        chk("bp_second_accepted", 128'(a_in_ready), 128'd0);
        n = 1;
        while (!a_out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_second_latency", 128'(n), 128'd5);
        chk("bp_second_data", a_out_data, ALL_ED);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;

        // Reset during BUSY pass 2
        a_in_data = FWD_IN; a_in_inv = 1'b0; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  128'(a_in_ready),  128'd1);
        chk("midrst_out_valid", 128'(a_out_valid), 128'd0);
        chk("midrst_out_data",  a_out_data,        128'd0);
        #3 rst_n = 1'b1;
        a_out_ready = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            stray = stray | a_out_valid;
        end
        a_out_ready = 1'b0;
        chk("midrst_no_stray_valid", 128'(stray), 128'd0);
        run_blk(1'b0, FWD_IN, 1'b0, 5, "post_rst", got);
        chk("post_rst_data", got, FWD_EXP);

        // Forward-only, single-pass instance: in_inv ignored, latency 2
        run_blk(1'b1, 128'h0000_0053, 1'b1, 2, "fwdonly", got);
        chk("fwdonly_data", got, 128'h6363_63ed);
        run_blk(1'b1, 128'hff53_0100, 1'b1, 2, "fwdonly2", got);
        chk("fwdonly2_data", got, 128'h16ed_7c63);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_sub_bytes_engine.md
# aes_sub_bytes_engine

Parametrised, multi-cycle SubBytes engine. It accepts a block of `DATA_BYTES` bytes over a valid/ready handshake and substitutes `LANES` bytes per cycle through the AES forward S-box, or optionally the inverse S-box. It returns the substituted block over a second valid/ready handshake. It sits between the round-state register and ShiftRows/MixColumns in area-constrained cipher cores, and in the key-expansion SubWord path with `DATA_BYTES=4`.

## Interface
- `DATA_BYTES`, default 16: bytes per block; must be ≥1.
- `LANES`, default 4: S-box instances per direction; must divide `DATA_BYTES`, otherwise an elaboration error.
- `ENABLE_INV`, default 1: 1 instantiates the inverse S-box lanes; 0 means `in_inv` is ignored and the engine is forward only.
- Derived: `PASSES = DATA_BYTES/LANES`; counter width `max(1, $clog2(PASSES))`.
- `clk`  input  1  sole clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  input block offered.
- `in_ready`  output  1  engine can accept a block.
- `in_data`  input  8*DATA_BYTES  block; byte i is `in_data[8*i +: 8]`.
- `in_inv`  input  1  0 = forward S-box, 1 = inverse S-box; sampled with the block.
- `out_valid`  output  1  result block available.
- `out_ready`  input  1  consumer accepts the result.
- `out_data`  output  8*DATA_BYTES  substituted block, same byte order as `in_data`.

## Operation
- State machine with three states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid & in_ready`: latch `in_data` into the source register, latch `in_inv` (forced to 0 when `ENABLE_INV=0`), clear the pass counter, go to BUSY.
- BUSY:
  - Each cycle, pass k (the counter value) looks up source bytes `k*LANES` to `k*LANES+LANES-1`, using the forward or inverse table per the latched mode.
  - It writes those bytes into the same positions of the result register, then increments the counter.
  - When k = `PASSES-1`, go to DONE.
  - If `PASSES=1`, BUSY lasts exactly one cycle.
- DONE:
  - `out_valid` = 1.
  - On `out_ready`: go to IDLE.
  - `out_data` and `out_valid` hold stable until accepted, regardless of `in_valid` or `in_inv`.
- `in_ready` is 0 in BUSY and DONE. `in_valid` is ignored there, and no input is lost or queued; the upstream must hold it.
- No combinational path exists from `out_ready` to `in_ready`.
- The mode and source bytes are taken only from the latched registers. Changes on `in_data`/`in_inv` after acceptance have no effect.
- Result register bytes not yet written in the current block retain stale values. This is invisible because `out_valid` = 0 until all passes complete.
- Forward tables are the standard FIPS-197 S-box. The inverse table is its exact inverse: inv(S(x)) = x for all 256 x.
- Reset, at any time including mid-BUSY or in DONE:
  - state → IDLE, counter → 0, result and source registers → 0, latched mode → 0.
  - Any in-flight block is discarded and no `out_valid` pulse follows.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_data` = 0.
- Acceptance edge is cycle 0.
- BUSY occupies cycles 1..`PASSES`.
- `out_valid` rises in cycle `PASSES+1`, so latency is `PASSES+1` cycles (5 for the defaults).
- If `out_ready` is already high, the output is consumed at the end of cycle `PASSES+1`, and `in_ready` returns high in cycle `PASSES+2`.
- Peak throughput is one block per `PASSES+2` cycles.
- All outputs are registered or decoded directly from state. S-box lookup is one combinational level between the source register and the result register.

## Test plan
- **Forward, defaults:** `in_data` bytes 0..15 = 0x00,0x01,0x53,0xff, then 0x00 repeated, `in_inv`=0 → after 5 cycles `out_valid`=1; bytes = 0x63,0x7c,0xed,0x16, then 0x63 repeated.
- **Inverse:** output of the previous test fed back with `in_inv`=1 → original block returned exactly. Also 0x63→0x00 and 0x16→0xff.
- **Exhaustive per parameter set:** (`DATA_BYTES`,`LANES`) ∈ {(16,4),(16,16),(4,1),(4,4)} × random blocks × both modes → compare against a reference model; latency equals `PASSES+1`; `PASSES=1` gives latency 2.
- **Backpressure:** hold `out_ready`=0 for 20 cycles with `in_valid` held high and `in_data` toggling → `out_data` stable, `in_ready`=0 throughout, the second block is accepted only after the output handshake.
- **Reset mid-operation:** assert `rst_n`=0 in BUSY pass 2 → immediately `in_ready`=1, `out_valid`=0, `out_data`=0; no stray `out_valid` afterwards; the next block completes correctly.
- **`ENABLE_INV=0`:** `in_inv`=1 with input 0x53 → output 0xed (forward applied).
